// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the slide-switch debouncer.
// Holds the per-bit FSM state type and the counter sizing helper.
package sw_debounce_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, IDLE/PENDING FSM and hold counter.
// change is a combinational accept strobe, high on the edge that updates stable.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic change
);

    // The IDLE->PENDING edge is the first of the DEBOUNCE_CYCLES samples,
    // so PENDING accepts once it has counted DEBOUNCE_CYCLES-2 further ones.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             sync1;
    logic             sync2;
    db_state_e        state;
    db_state_e        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             stable_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            stable <= stable_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        stable_nx = stable;
        change    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (sync2 != stable) begin
                    state_nx = PENDING;
                end
            end
            PENDING: begin
                if (sync2 == stable) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    stable_nx = sync2;
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                    change    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch front end feeding the switch PIO in_port.
// Adds the aggregate change pulse and sticky write-one-to-clear flags.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] edge_capture,
    input  logic             clear_strobe,
    input  logic [WIDTH-1:0] clear_mask
);

    logic [WIDTH-1:0] change_vec;
    logic [WIDTH-1:0] clr_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .stable(sw_stable[i]),
            .change(change_vec[i])
        );
    end

    assign clr_vec = clear_strobe ? clear_mask : '0;

    // A new change outranks a clear landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_changed   <= 1'b0;
            edge_capture <= '0;
        end else begin
            sw_changed   <= |change_vec;
            edge_capture <= (edge_capture & ~clr_vec) | change_vec;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a short hold time.
// Reference model counts consecutive differing synchronised samples per bit.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W  = 10;
    localparam int DC = DEBOUNCE_CYCLES_SIM;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic         sw_changed;
    logic [W-1:0] edge_capture;
    logic         clear_strobe;
    logic [W-1:0] clear_mask;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_s1, m_s2, m_stable, m_ec;
    logic         m_changed;
    int           run [W];

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .sw_stable   (sw_stable),
        .sw_changed  (sw_changed),
        .edge_capture(edge_capture),
        .clear_strobe(clear_strobe),
        .clear_mask  (clear_mask)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_ec = '0; m_changed = 1'b0;
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    // Advance one edge, update the model, return 1 time unit after the edge.
    task automatic tick();
        logic [W-1:0] pulses;
        logic [W-1:0] clr;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            pulses = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] == DC) begin
                        m_stable[i] = m_s2[i];
                        run[i] = 0;
                        pulses[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            clr = clear_strobe ? clear_mask : '0;
            m_changed = |pulses;
            m_ec = (m_ec & ~clr) | pulses;
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sw_raw = '0; clear_strobe = 1'b0; clear_mask = '0;
        model_reset();
        tick(); tick();
        checks++;
        if (sw_stable !== '0 || edge_capture !== '0 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stable=%h ec=%h chg=%b want 0", sw_stable, edge_capture, sw_changed);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (sw_changed !== 1'b0 || sw_stable !== '0) begin
                errors++;
                $display("FAIL idle_zero c=%0d: stable=%h chg=%b want 0", c, sw_stable, sw_changed);
            end
        end
        checks++;
        if (edge_capture !== '0) begin
            errors++;
            $display("FAIL idle_ec: got %h want 0", edge_capture);
        end
    endtask

    task automatic test_single_rise();
        sw_raw[0] = 1'b1;
        tick();
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (sw_stable[0] !== (e >= 5) || sw_changed !== (e == 5)) begin
                errors++;
                $display("FAIL rise_b0 edge=%0d: stable0=%b chg=%b want %b %b", e, sw_stable[0], sw_changed, e >= 5, e == 5);
            end
        end
        checks++;
        if (edge_capture !== 10'h001) begin
            errors++;
            $display("FAIL rise_ec: got %h want 001", edge_capture);
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                sw_raw[3] = (k < 2);
                tick();
                if (sw_changed) np++;
                checks++;
                if (sw_stable[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_hold r=%0d: stable3=%b want 0", r, sw_stable[3]);
                end
            end
        end
        sw_raw[3] = 1'b1;
        tick();
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (sw_changed) np++;
            checks++;
            if (sw_stable[3] !== (e == 5)) begin
                errors++;
                $display("FAIL bounce_rise edge=%0d: stable3=%b want %b", e, sw_stable[3], e == 5);
            end
        end
        tick();
        if (sw_changed) np++;
        checks++;
        if (np != 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d want 1", np);
        end
    endtask

    task automatic test_clear();
        sw_raw[0] = 1'b0;
        tick();
        for (int e = 1; e <= 4; e++) tick();
        clear_strobe = 1'b1; clear_mask = 10'h001;
        tick();
        checks++;
        if (sw_changed !== 1'b1 || edge_capture !== 10'h009) begin
            errors++;
            $display("FAIL clear_set_wins: chg=%b ec=%h want 1 009", sw_changed, edge_capture);
        end
        tick();
        checks++;
        if (edge_capture !== 10'h008) begin
            errors++;
            $display("FAIL clear_next: ec=%h want 008", edge_capture);
        end
        clear_strobe = 1'b0; clear_mask = 10'h3FF;
        tick();
        checks++;
        if (edge_capture !== 10'h008) begin
            errors++;
            $display("FAIL clear_no_strobe: ec=%h want 008", edge_capture);
        end
        clear_strobe = 1'b1;
        tick();
        clear_strobe = 1'b0; clear_mask = '0;
        checks++;
        if (edge_capture !== '0) begin
            errors++;
            $display("FAIL clear_all: ec=%h want 000", edge_capture);
        end
    endtask

    task automatic test_all_bits();
        int np = 0;
        sw_raw = '0;
        for (int c = 0; c < 10; c++) tick();
        clear_strobe = 1'b1; clear_mask = 10'h3FF;
        tick();
        clear_strobe = 1'b0; clear_mask = '0;
        sw_raw = 10'h3FF;
        tick();
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (sw_changed) np++;
            if (e == 4 || e == 5) begin
                checks++;
                if (sw_stable !== ((e == 5) ? 10'h3FF : 10'h000)) begin
                    errors++;
                    $display("FAIL all_bits edge=%0d: stable=%h", e, sw_stable);
                end
            end
        end
        checks++;
        if (np != 1 || edge_capture !== 10'h3FF) begin
            errors++;
            $display("FAIL all_bits_pulse: pulses=%0d ec=%h want 1 3ff", np, edge_capture);
        end
    endtask

    task automatic test_reset_pending();
        sw_raw = '0;
        for (int c = 0; c < 10; c++) tick();
        sw_raw[9] = 1'b1;
        tick();
        for (int e = 1; e <= 4; e++) tick();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (sw_stable !== '0 || edge_capture !== '0 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: stable=%h ec=%h chg=%b want 0", sw_stable, edge_capture, sw_changed);
        end
        tick(); tick();
        checks++;
        if (sw_stable !== '0 || edge_capture !== '0) begin
            errors++;
            $display("FAIL rst_held: stable=%h ec=%h want 0", sw_stable, edge_capture);
        end
        reset = 1'b0;
        tick();
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (sw_stable !== ((e == 5) ? 10'h200 : 10'h000)) begin
                errors++;
                $display("FAIL rst_rerun edge=%0d: stable=%h want %h", e, sw_stable, (e == 5) ? 10'h200 : 10'h000);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) sw_raw = W'($urandom);
            clear_strobe = ($urandom_range(0, 7) == 0);
            clear_mask = W'($urandom);
            tick();
            checks++;
            if (sw_stable !== m_stable || sw_changed !== m_changed || edge_capture !== m_ec) begin
                errors++;
                $display("FAIL random c=%0d: stable=%h chg=%b ec=%h want %h %b %h",
                         c, sw_stable, sw_changed, edge_capture, m_stable, m_changed, m_ec);
            end
        end
        clear_strobe = 1'b0; clear_mask = '0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_bounce();
        test_clear();
        test_all_bits();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
